mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that consumes the two register-file read operands and produces the MIPS HI/LO result pair.
- Sits directly downstream of the register file: operand A comes from RF_Data1 (rs), operand B from RF_Data2 (rt).
- HI/LO feed the MFHI/MFLO path back toward the register-file write-data mux.
- Control asserts MD_Start for one cycle and stalls the PC while MD_Busy is high.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST_N  input  1  asynchronous active-low reset
- MD_Start  input  1  one-cycle request; sampled only when MD_Busy=0
- MD_Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- MD_Operand_A  input  DATA_WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
- MD_Operand_B  input  DATA_WIDTH  rt value (multiplier / divisor)
- MD_Busy  output  1  high while an iterative operation is in flight
- MD_Done  output  1  one-cycle pulse when HI/LO hold a new MULT/DIV result
- MD_HI  output  DATA_WIDTH  HI register (upper product / remainder)
- MD_LO  output  DATA_WIDTH  LO register (lower product / quotient)
- MD_Div_By_Zero  output  1  sticky flag, set by a DIV/DIVU with B=0, cleared by the next accepted Start

Behaviour:
- Reset (RST_N low, asynchronous, any state):
  - State returns to IDLE.
  - MD_HI, MD_LO, the counter and internal operand registers clear to 0.
  - MD_Busy, MD_Done and MD_Div_By_Zero clear to 0.
  - An in-flight operation is discarded with no Done pulse.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, on edge k with MD_Start=1:
  - MULT/DIV variants: latch |A| and |B| (signed ops take the absolute value; unsigned ops pass through), latch result signs, clear the counter, go to RUN. MD_Busy=1 from edge k.
  - MTHI/MTLO: write A into HI/LO at edge k. Stay IDLE; no Busy, no Done.
  - Opcode 110/111: ignored.
- RUN, edges k+1 .. k+DATA_WIDTH, one iteration per edge:
  - Multiply: shift-add, 2*DATA_WIDTH-bit unsigned accumulator.
  - Divide: restoring step — shift the remainder left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
  - Counter width is clog2(DATA_WIDTH)+1; leave RUN when the counter reaches DATA_WIDTH-1.
- FIX, edge k+DATA_WIDTH+1:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI/LO at this edge; MD_Done=1 for exactly the following cycle; MD_Busy deasserts at the same edge.
  - Total: MD_Busy high for DATA_WIDTH+1 = 33 cycles.
- Divide by zero (B=0, DIV or DIVU):
  - Full latency is still taken.
  - FIX overrides the result: HI = original A (raw bits), LO = all ones.
  - MD_Div_By_Zero=1.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. No flag, no trap.
- MD_Start while MD_Busy=1 (any opcode, including MTHI/MTLO) is ignored; in-flight operands are unaffected.
- MD_Start in the same cycle as the MD_Done pulse is legal: the unit is in IDLE, so the new op is accepted.
- HI/LO hold their value between writes; they never show intermediate accumulator contents.
- Operands are sampled only at acceptance; A/B changing during RUN has no effect.

Decomposition:
- Shared package holds:
  - Opcode constants MD_OP_MULT .. MD_OP_MTLO.
  - DATA_WIDTH default.
  - State encoding (IDLE, RUN, FIX).
  - Opcode-decode helpers: is_signed, is_div.
- One natural combinational sub-module, mdu_div_step: one restoring-division iteration (inputs: remainder, dividend bit, divisor; outputs: next remainder, quotient bit). The multiply step stays inline.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> MD_Done exactly 33 cycles after the Start edge; HI=0xFFFFFFFE, LO=0x00000001; MD_Busy high for 33 cycles.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5 B=0 -> HI=5, LO=0xFFFFFFFF, MD_Div_By_Zero=1; next accepted MULT 2*3 clears the flag, HI=0, LO=6.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, no flag.
- Start MULTU 3*4, then MTHI A=0x1234 and MULT 9*9 while busy -> both ignored; HI=0, LO=12. MTLO A=0xABCD in IDLE -> LO=0xABCD next cycle, no Done.
- Start DIV 50/5, assert RST_N=0 asynchronously at cycle 10 of RUN -> Busy, Done, HI, LO all 0 immediately; no Done after release; next DIVU 50/5 gives LO=10, HI=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encoding and small opcode-decode helpers.
package mult_div_unit_pkg;

   // Default operand/result width; the iteration count equals this width.
   localparam int MD_DATA_WIDTH = 32;

   // MD_Op encoding.
   localparam logic [2:0] MD_OP_MULT  = 3'b000;
   localparam logic [2:0] MD_OP_MULTU = 3'b001;
   localparam logic [2:0] MD_OP_DIV   = 3'b010;
   localparam logic [2:0] MD_OP_DIVU  = 3'b011;
   localparam logic [2:0] MD_OP_MTHI  = 3'b100;
   localparam logic [2:0] MD_OP_MTLO  = 3'b101;

   // FSM state encoding.
   localparam logic [1:0] MD_ST_IDLE = 2'd0;
   localparam logic [1:0] MD_ST_RUN  = 2'd1;
   localparam logic [1:0] MD_ST_FIX  = 2'd2;

   // Signed variants take absolute values on entry and fix signs on exit.
   function automatic logic is_signed(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

   // Divide variants use the restoring-division datapath.
   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

   // Opcodes that launch an iterative operation (MULT/MULTU/DIV/DIVU).
   function automatic logic is_iter(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference
// when it is non-negative.
module mdu_div_step
   import mult_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] rem_in,
   input  logic                  dividend_bit,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] rem_out,
   output logic                  q_bit
);

   // One extra bit holds the shifted-out remainder MSB; the same bit of the
   // difference is the borrow that decides the quotient bit.
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;

   assign shifted = {rem_in, dividend_bit};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[DATA_WIDTH];
   assign rem_out = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit producing the HI/LO pair.
// Magnitudes are processed unsigned over DATA_WIDTH iterations; the FIX
// state restores signs (or applies the divide-by-zero result) and writes
// HI/LO in a single edge so intermediate values are never visible.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  MD_Start,
   input  logic [2:0]            MD_Op,
   input  logic [DATA_WIDTH-1:0] MD_Operand_A,
   input  logic [DATA_WIDTH-1:0] MD_Operand_B,
   output logic                  MD_Busy,
   output logic                  MD_Done,
   output logic [DATA_WIDTH-1:0] MD_HI,
   output logic [DATA_WIDTH-1:0] MD_LO,
   output logic                  MD_Div_By_Zero
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam int AW    = 2 * DATA_WIDTH;

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [2:0]            op_q;
   logic [DATA_WIDTH-1:0] opnd;      // |multiplicand| or |divisor|
   logic [DATA_WIDTH-1:0] a_raw;     // raw operand A for the divide-by-zero result
   logic [AW-1:0]         acc;       // product, or {remainder, dividend/quotient}
   logic                  neg_q;     // product/quotient sign differs
   logic                  neg_r;     // remainder takes the dividend's sign

   logic                  idle;
   logic                  accept_iter;
   logic                  accept_mthi;
   logic                  accept_mtlo;
   logic                  last_iter;
   logic                  a_neg;
   logic                  b_neg;
   logic [DATA_WIDTH-1:0] a_abs;
   logic [DATA_WIDTH-1:0] b_abs;

   logic [DATA_WIDTH:0]   mul_sum;
   logic [AW-1:0]         mul_next;
   logic [DATA_WIDTH-1:0] div_rem;
   logic                  div_qbit;
   logic [AW-1:0]         div_next;

   logic [AW-1:0]         prod_fix;
   logic [DATA_WIDTH-1:0] res_hi;
   logic [DATA_WIDTH-1:0] res_lo;
   logic                  res_dbz;

   assign idle        = (state == MD_ST_IDLE);
   assign accept_iter = idle && MD_Start && is_iter(MD_Op);
   assign accept_mthi = idle && MD_Start && (MD_Op == MD_OP_MTHI);
   assign accept_mtlo = idle && MD_Start && (MD_Op == MD_OP_MTLO);
   assign last_iter   = (cnt == CNT_W'(DATA_WIDTH - 1));
   assign MD_Busy     = !idle;

   // Operand magnitudes; unsigned ops pass straight through.
   assign a_neg = is_signed(MD_Op) && MD_Operand_A[DATA_WIDTH-1];
   assign b_neg = is_signed(MD_Op) && MD_Operand_B[DATA_WIDTH-1];
   assign a_abs = a_neg ? -MD_Operand_A : MD_Operand_A;
   assign b_abs = b_neg ? -MD_Operand_B : MD_Operand_B;

   // Shift-add multiply step: the multiplier sits in the low half of acc and
   // is consumed LSB first while the product grows in from the top.
   assign mul_sum  = {1'b0, acc[AW-1:DATA_WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[DATA_WIDTH-1:1]};

   // Restoring divide step: dividend bits leave acc MSB first from the low
   // half while quotient bits enter at the bottom.
   mdu_div_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_div_step (
      .rem_in       (acc[AW-1:DATA_WIDTH]),
      .dividend_bit (acc[DATA_WIDTH-1]),
      .divisor      (opnd),
      .rem_out      (div_rem),
      .q_bit        (div_qbit)
   );

   assign div_next = {div_rem, acc[DATA_WIDTH-2:0], div_qbit};

   // Final HI/LO values selected in FIX: sign-corrected result or div-by-zero override.
   always_comb begin
      prod_fix = '0;
      res_hi   = '0;
      res_lo   = '0;
      res_dbz  = 1'b0;
      if (is_div(op_q)) begin
         if (opnd == '0) begin
            res_hi  = a_raw;
            res_lo  = '1;
            res_dbz = 1'b1;
         end else begin
            res_hi = neg_r ? -acc[AW-1:DATA_WIDTH] : acc[AW-1:DATA_WIDTH];
            res_lo = neg_q ? -acc[DATA_WIDTH-1:0]  : acc[DATA_WIDTH-1:0];
         end
      end else begin
         prod_fix = neg_q ? -acc : acc;
         res_hi   = prod_fix[AW-1:DATA_WIDTH];
         res_lo   = prod_fix[DATA_WIDTH-1:0];
      end
   end

   // Control: IDLE -> RUN -> FIX -> IDLE sequencing, iteration counter, Done pulse, sticky flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state          <= MD_ST_IDLE;
         cnt            <= '0;
         op_q           <= '0;
         MD_Done        <= 1'b0;
         MD_Div_By_Zero <= 1'b0;
      end else begin
         MD_Done <= 1'b0;
         case (state)
            MD_ST_IDLE: begin
               if (accept_iter || accept_mthi || accept_mtlo) begin
                  MD_Div_By_Zero <= 1'b0;
               end
               if (accept_iter) begin
                  op_q  <= MD_Op;
                  cnt   <= '0;
                  state <= MD_ST_RUN;
               end
            end
            MD_ST_RUN: begin
               if (last_iter) begin
                  state <= MD_ST_FIX;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            MD_ST_FIX: begin
               MD_Done        <= 1'b1;
               MD_Div_By_Zero <= res_dbz;
               state          <= MD_ST_IDLE;
            end
            default: begin
               state <= MD_ST_IDLE;
            end
         endcase
      end
   end

   // Datapath: latch magnitudes and signs on acceptance, iterate during RUN.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         opnd  <= '0;
         a_raw <= '0;
         acc   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept_iter) begin
         a_raw <= MD_Operand_A;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         if (is_div(MD_Op)) begin
            opnd <= b_abs;
            acc  <= {{DATA_WIDTH{1'b0}}, a_abs};
         end else begin
            opnd <= a_abs;
            acc  <= {{DATA_WIDTH{1'b0}}, b_abs};
         end
      end else if (state == MD_ST_RUN) begin
         acc <= is_div(op_q) ? div_next : mul_next;
      end
   end

   // HI/LO architectural registers: written by MTHI/MTLO in IDLE or by FIX only.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         MD_HI <= '0;
         MD_LO <= '0;
      end else if (state == MD_ST_FIX) begin
         MD_HI <= res_hi;
         MD_LO <= res_lo;
      end else begin
         if (accept_mthi) begin
            MD_HI <= MD_Operand_A;
         end
         if (accept_mtlo) begin
            MD_LO <= MD_Operand_A;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected HI/LO/flag
// values from an arithmetic reference model; a monitor pops and compares
// whenever MD_Done is presented.
module tb_mult_div_unit;

   localparam int W = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         MD_Start = 1'b0;
   logic [2:0]   MD_Op = 3'd7;
   logic [W-1:0] MD_Operand_A = '0;
   logic [W-1:0] MD_Operand_B = '0;
   logic         MD_Busy;
   logic         MD_Done;
   logic [W-1:0] MD_HI;
   logic [W-1:0] MD_LO;
   logic         MD_Div_By_Zero;

   mult_div_unit #(.DATA_WIDTH(W)) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .MD_Start       (MD_Start),
      .MD_Op          (MD_Op),
      .MD_Operand_A   (MD_Operand_A),
      .MD_Operand_B   (MD_Operand_B),
      .MD_Busy        (MD_Busy),
      .MD_Done        (MD_Done),
      .MD_HI          (MD_HI),
      .MD_LO          (MD_LO),
      .MD_Div_By_Zero (MD_Div_By_Zero)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference model: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t    e;
      longint  sa;
      longint  sb_v;
      longint  r;
      longint  q;
      e.hi  = '0;
      e.lo  = '0;
      e.dbz = 1'b0;
      sa    = longint'($signed(a));
      sb_v  = longint'($signed(b));
      case (op)
         OP_MULT: begin
            r    = sa * sb_v;
            e.hi = r[63:32];
            e.lo = r[31:0];
         end
         OP_MULTU: begin
            r    = longint'({32'd0, a}) * longint'({32'd0, b});
            e.hi = r[63:32];
            e.lo = r[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (b == '0) begin
               e.hi  = a;
               e.lo  = '1;
               e.dbz = 1'b1;
            end else if (op == OP_DIV) begin
               q    = sa / sb_v;
               r    = sa % sb_v;
               e.hi = r[31:0];
               e.lo = q[31:0];
            end else begin
               q    = longint'({32'd0, a}) / longint'({32'd0, b});
               r    = longint'({32'd0, a}) % longint'({32'd0, b});
               e.hi = r[31:0];
               e.lo = q[31:0];
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (RST_N && MD_Done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("hi", 64'(MD_HI), 64'(e.hi));
            check("lo", 64'(MD_LO), 64'(e.lo));
            check("div_by_zero", 64'(MD_Div_By_Zero), 64'(e.dbz));
         end
      end
   end

   // Drive a Start at the current negedge; returns at the negedge after acceptance.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (op <= OP_DIVU) sb.push_back(model(op, a, b));
      MD_Start     = 1'b1;
      MD_Op        = op;
      MD_Operand_A = a;
      MD_Operand_B = b;
      @(negedge CLK);
      MD_Start     = 1'b0;
      MD_Op        = 3'($urandom_range(0, 7));
      MD_Operand_A = $urandom;
      MD_Operand_B = $urandom;
   endtask

   // Wait for Done with a bound; checks latency and Busy width. Optionally
   // fires MTHI and MULT starts while busy, which must be ignored.
   task automatic wait_done(input bit inject);
      int n;
      int busy;
      n    = 1;
      busy = MD_Busy ? 1 : 0;
      while (!MD_Done && n < 60) begin
         @(negedge CLK);
         n++;
         if (MD_Busy) busy++;
         if (inject) begin
            if (n == 3) begin
               MD_Start = 1'b1; MD_Op = OP_MTHI; MD_Operand_A = 32'h1234;
            end else if (n == 4) begin
               MD_Start = 1'b1; MD_Op = OP_MULT; MD_Operand_A = 32'd9; MD_Operand_B = 32'd9;
            end else begin
               MD_Start = 1'b0;
            end
         end
      end
      MD_Start = 1'b0;
      check("done_latency", 64'(n - 1), 64'd33);
      check("busy_cycles", 64'(busy), 64'd33);
   endtask

   task automatic md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      issue(op, a, b);
      wait_done(1'b0);
   endtask

   task automatic mt(input logic [2:0] op, input logic [W-1:0] a);
      issue(op, a, '0);
      if (op == OP_MTHI) check("mthi", 64'(MD_HI), 64'(a));
      else               check("mtlo", 64'(MD_LO), 64'(a));
      check("mt_no_done", 64'(MD_Done), 64'd0);
   endtask

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_busy", 64'(MD_Busy), 64'd0);
      check("rst_done", 64'(MD_Done), 64'd0);
      check("rst_hi", 64'(MD_HI), 64'd0);
      check("rst_lo", 64'(MD_LO), 64'd0);
      check("rst_dbz", 64'(MD_Div_By_Zero), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      // Directed cases; each new op is issued in the Done cycle of the last.
      md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      md(OP_MULT,  32'hFFFF_FFFD, 32'd7);
      md(OP_DIVU,  32'd100, 32'd7);
      md(OP_DIV,   32'hFFFF_FFF9, 32'd2);
      md(OP_DIV,   32'd5, 32'd0);
      md(OP_MULT,  32'd2, 32'd3);
      md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

      // Starts while busy are ignored
      issue(OP_MULTU, 32'd3, 32'd4);
      wait_done(1'b1);
      @(negedge CLK);
      check("hi_hold_after_ignored", 64'(MD_HI), 64'd0);
      check("lo_hold_after_ignored", 64'(MD_LO), 64'd12);
      mt(OP_MTLO, 32'hABCD);
      @(negedge CLK);
      check("mtlo_hold", 64'(MD_LO), 64'hABCD);

      // Asynchronous reset mid-RUN
      issue(OP_DIV, 32'd50, 32'd5);
      repeat (9) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("arst_busy", 64'(MD_Busy), 64'd0);
      check("arst_done", 64'(MD_Done), 64'd0);
      check("arst_hi", 64'(MD_HI), 64'd0);
      check("arst_lo", 64'(MD_LO), 64'd0);
      void'(sb.pop_back());
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (40) @(negedge CLK);
      check("post_rst_busy", 64'(MD_Busy), 64'd0);
      md(OP_DIVU, 32'd50, 32'd5);

      // Randomized mix
      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 5));
         if (op >= OP_MTHI) mt(op, $urandom);
         else               md(op, pick_val(), pick_val());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      end

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
